// File: rtl/matrix_c_streamer.sv
// Captures a 16-element result matrix in one cycle and streams it out one element per beat
// over valid/ready, then reports an XOR checksum of the streamed elements.
module matrix_c_streamer #(
  parameter int unsigned N_ELEM = 16,
  parameter int unsigned ELEM_W = 20,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     c_valid,
  input  logic [N_ELEM*ELEM_W-1:0] matrix_C,
  output logic                     c_ready,
  output logic [ELEM_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [ELEM_W-1:0]        checksum,
  output logic                     checksum_valid,
  output logic                     busy
);

  typedef enum logic [1:0] {StIdle, StStream, StCsum} state_e;

  state_e                   state_q, state_d;
  logic [N_ELEM*ELEM_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ELEM_W-1:0]        xor_q, xor_d;
  logic [ELEM_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [ELEM_W-1:0]        checksum_q, checksum_d;
  logic                     checksum_valid_q, checksum_valid_d;
  logic [IDX_W-1:0]         nxt_idx;

  assign nxt_idx = idx_q + IDX_W'(1);

  always_comb begin
    state_d          = state_q;
    shadow_d         = shadow_q;
    idx_d            = idx_q;
    xor_d            = xor_q;
    out_data_d       = out_data_q;
    out_valid_d      = out_valid_q;
    out_last_d       = out_last_q;
    checksum_d       = checksum_q;
    checksum_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (c_valid) begin
          shadow_d    = matrix_C;
          idx_d       = '0;
          xor_d       = '0;
          out_data_d  = matrix_C[ELEM_W-1:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = StStream;
        end
      end
      StStream: begin
        if (out_ready) begin
          xor_d = xor_q ^ out_data_q;
          if (idx_q == IDX_W'(N_ELEM - 1)) begin
            // idx stays at the last element; the stream always ends in the checksum beat
            out_valid_d      = 1'b0;
            out_last_d       = 1'b0;
            checksum_d       = xor_q ^ out_data_q;
            checksum_valid_d = 1'b1;
            state_d          = StCsum;
          end else begin
            idx_d      = nxt_idx;
            out_data_d = shadow_q[ELEM_W*nxt_idx +: ELEM_W];
            out_last_d = (nxt_idx == IDX_W'(N_ELEM - 1));
          end
        end
      end
      StCsum: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      shadow_q         <= '0;
      idx_q            <= '0;
      xor_q            <= '0;
      out_data_q       <= '0;
      out_valid_q      <= 1'b0;
      out_last_q       <= 1'b0;
      checksum_q       <= '0;
      checksum_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      shadow_q         <= shadow_d;
      idx_q            <= idx_d;
      xor_q            <= xor_d;
      out_data_q       <= out_data_d;
      out_valid_q      <= out_valid_d;
      out_last_q       <= out_last_d;
      checksum_q       <= checksum_d;
      checksum_valid_q <= checksum_valid_d;
    end
  end

  assign c_ready        = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign out_data       = out_data_q;
  assign out_idx        = idx_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign checksum       = checksum_q;
  assign checksum_valid = checksum_valid_q;

endmodule

// File: tb/tb_matrix_c_streamer.sv
// Randomized self-checking bench for matrix_c_streamer: expected beats and checksum come from
// an element array and an XOR reduction computed here.
module tb_matrix_c_streamer;

  logic         clock;
  logic         rst;
  logic         c_valid;
  logic [319:0] matrix_C;
  logic         c_ready;
  logic [19:0]  out_data;
  logic [3:0]   out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [19:0]  checksum;
  logic         checksum_valid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_el [16];
  logic [19:0] last_csum;

  matrix_c_streamer dut (
    .clock          (clock),
    .rst            (rst),
    .c_valid        (c_valid),
    .matrix_C       (matrix_C),
    .c_ready        (c_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .checksum       (checksum),
    .checksum_valid (checksum_valid),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout required completion");
    $fatal(1, "simulation timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic randomize_bus();
    for (int w = 0; w < 10; w++) matrix_C[w*32 +: 32] = $urandom();
  endtask

  task automatic check_reset_outputs(input string tag, input logic [19:0] csum);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_out_data"}, out_data, 0);
    check_eq({tag, "_out_idx"}, out_idx, 0);
    check_eq({tag, "_out_last"}, out_last, 0);
    check_eq({tag, "_checksum"}, checksum, csum);
    check_eq({tag, "_csum_valid"}, checksum_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_c_ready"}, c_ready, 1);
  endtask

  // Capture exp_el, then drain it. bp_pct: random stall probability; hold_at: stall 3 cycles
  // at that index; inject: toggle c_valid with junk during the stream; abort_at: reset there.
  task automatic run_stream(input int bp_pct, input int hold_at, input bit inject,
                            input int abort_at);
    logic [19:0] exp_x;
    int k, cycles, held;
    exp_x = '0;
    for (int i = 0; i < 16; i++) exp_x ^= exp_el[i];
    check_eq("idle_c_ready", c_ready, 1);
    for (int i = 0; i < 16; i++) matrix_C[i*20 +: 20] = exp_el[i];
    c_valid = 1'b1;
    @(negedge clock);
    c_valid = 1'b0;
    randomize_bus();
    check_eq("valid_after_capture", out_valid, 1);
    k = 0;
    cycles = 0;
    held = 0;
    while (k < 16 && cycles < 400) begin
      check_eq("stream_c_ready", c_ready, 0);
      check_eq("stream_busy", busy, 1);
      check_eq("stream_csum_valid", checksum_valid, 0);
      check_eq("stream_checksum_held", checksum, last_csum);
      check_eq("stream_out_valid", out_valid, 1);
      check_eq("beat_idx", out_idx, k);
      check_eq("beat_data", out_data, exp_el[k]);
      check_eq("beat_last", out_last, (k == 15));
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort", '0);
        last_csum = '0;
        @(negedge clock);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clock);
          check_eq("abort_no_csum_pulse", checksum_valid, 0);
          check_eq("abort_idle", c_ready, 1);
          check_eq("abort_no_valid", out_valid, 0);
        end
        out_ready = 1'b0;
        return;
      end
      if (k == hold_at && held < 3) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = ($urandom_range(99) >= bp_pct);
      end
      if (inject) begin
        c_valid = $urandom_range(1);
        randomize_bus();
      end
      @(posedge clock);
      if (out_ready) k++;
      cycles++;
      @(negedge clock);
    end
    c_valid = 1'b0;
    check_eq("stream_beats", k, 16);
    if (bp_pct == 0 && hold_at < 0) check_eq("stream_consecutive", cycles, 16);
    if (hold_at >= 0) check_eq("stream_hold_cycles", cycles, 19);
    out_ready = $urandom_range(1);
    check_eq("csum_pulse", checksum_valid, 1);
    check_eq("csum_value", checksum, exp_x);
    check_eq("csum_out_valid", out_valid, 0);
    check_eq("csum_busy", busy, 1);
    @(negedge clock);
    check_eq("csum_pulse_end", checksum_valid, 0);
    check_eq("csum_hold", checksum, exp_x);
    check_eq("back_idle", c_ready, 1);
    check_eq("back_not_busy", busy, 0);
    last_csum = exp_x;
    out_ready = 1'b0;
  endtask

  initial begin
    int a [16];
    int b [16];
    rst = 1'b1;
    c_valid = 1'b0;
    out_ready = 1'b0;
    matrix_C = '0;
    last_csum = '0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset", '0);
    rst = 1'b0;
    @(negedge clock);

    // Matrix product of A = 0..15 and B = 10..25, row-major
    for (int i = 0; i < 16; i++) begin
      a[i] = i;
      b[i] = i + 10;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int s;
        s = 0;
        for (int t = 0; t < 4; t++) s += a[r*4+t] * b[t*4+c];
        exp_el[r*4+c] = 20'(s);
      end
    run_stream(0, -1, 1'b0, -1);

    // Mid-cycle reset with no clock edge clears everything, including the checksum
    @(posedge clock);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midcycle_reset", '0);
    last_csum = '0;
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 16; i++) exp_el[i] = 20'(i + 1);
    run_stream(0, -1, 1'b0, -1);
    for (int i = 0; i < 16; i++) exp_el[i] = 20'hFFFFF;
    run_stream(0, -1, 1'b0, -1);

    for (int i = 0; i < 16; i++) exp_el[i] = 20'($urandom());
    run_stream(0, 5, 1'b0, -1);

    for (int i = 0; i < 16; i++) exp_el[i] = 20'($urandom());
    run_stream(20, -1, 1'b1, -1);

    for (int i = 0; i < 16; i++) exp_el[i] = 20'($urandom());
    run_stream(0, -1, 1'b0, 9);
    for (int i = 0; i < 16; i++) exp_el[i] = 20'($urandom());
    run_stream(0, -1, 1'b0, -1);

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) exp_el[i] = 20'($urandom());
      run_stream(40, -1, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
